// File: rtl/layer_stream_ctrl.sv
// Frame sequencer for one conv+maxpool layer stage. It streams a WIDTH x WIDTH map from a source
// RAM into the layer and collects the pooled outputs into a destination RAM by address.
module layer_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_CH      = 3,
    parameter int unsigned OUT_CH     = 8,
    parameter int unsigned WIDTH      = 112,
    parameter int unsigned DRAIN_MAX  = 1023,
    localparam int unsigned DIM       = WIDTH * WIDTH,
    localparam int unsigned DOUT      = (WIDTH / 2) * (WIDTH / 2),
    localparam int unsigned AW        = $clog2(DIM),
    localparam int unsigned OW        = $clog2(DOUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        src_ready,
    output logic                        rd_en,
    output logic [AW-1:0]               rd_addr,
    input  logic [DATA_WIDTH*IN_CH-1:0] rd_data,
    output logic [DATA_WIDTH*IN_CH-1:0] lyr_data,
    output logic                        lyr_valid,
    input  logic                        lyr_valid_out,
    output logic                        wr_en,
    output logic [OW-1:0]               wr_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    output logic                        err_overflow
);

    localparam int unsigned CW = $clog2(DOUT + 1);
    localparam int unsigned DW = $clog2(DRAIN_MAX + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DIM - 1);
    localparam logic [CW-1:0] OUT_FULL  = CW'(DOUT);
    localparam logic [DW-1:0] DRAIN_LIM = DW'(DRAIN_MAX);

    if (WIDTH < 2 || (WIDTH % 2) != 0 || IN_CH == 0 || OUT_CH == 0) begin : g_bad_params
        $error("layer_stream_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_t;

    state_t        state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_nxt;
    logic          capture;
    logic          out_full;

    assign capture  = (state == StFeed) || (state == StDrain);
    assign out_full = (out_cnt == OUT_FULL);
    assign rd_en    = (state == StFeed) && src_ready;
    assign lyr_data = rd_data;
    assign wr_en    = capture && lyr_valid_out && !out_full;
    assign wr_addr  = out_cnt[OW-1:0];

    assign out_cnt_nxt = wr_en ? out_cnt + 1'b1 : out_cnt;

    // Drain counter saturates rather than wrapping; any layer output restarts the idle window.
    assign drain_nxt = lyr_valid_out ? '0 :
                       (drain_cnt == DRAIN_LIM) ? drain_cnt : drain_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            rd_addr      <= '0;
            lyr_valid    <= 1'b0;
            out_cnt      <= '0;
            drain_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            lyr_valid <= rd_en;
            out_cnt   <= out_cnt_nxt;
            if (capture && lyr_valid_out && out_full) begin
                err_overflow <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state        <= StFeed;
                        busy         <= 1'b1;
                        rd_addr      <= '0;
                        out_cnt      <= '0;
                        drain_cnt    <= '0;
                        err_timeout  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                StFeed: begin
                    if (src_ready) begin
                        if (rd_addr == LAST_ADDR) begin
                            rd_addr <= '0;
                            state   <= StDrain;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    drain_cnt <= drain_nxt;
                    // Look at next-state counts so DONE follows the final write by one cycle.
                    if (out_cnt_nxt == OUT_FULL) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (drain_nxt == DRAIN_LIM) begin
                        err_timeout <= 1'b1;
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Scoreboard bench for layer_stream_ctrl: a small WIDTH=8 instance for directed frames and a
// full-size WIDTH=112 instance under a throttled source.
`timescale 1ns/1ps
module tb_layer_stream_ctrl;

    localparam int DIM_A  = 64;
    localparam int DOUT_A = 16;
    localparam int DIM_B  = 12544;
    localparam int DOUT_B = 3136;

    typedef struct {
        int addr;
        int c;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, src_ready_a, rd_en_a, lyr_valid_a, lvo_a, wr_en_a;
    logic        busy_a, done_a, err_to_a, err_ov_a;
    logic [5:0]  rd_addr_a;
    logic [3:0]  wr_addr_a;
    logic [95:0] rd_data_a, lyr_data_a;

    logic        start_b, src_ready_b, rd_en_b, lyr_valid_b, lvo_b, wr_en_b;
    logic        busy_b, done_b, err_to_b, err_ov_b;
    logic [13:0] rd_addr_b;
    logic [11:0] wr_addr_b;
    logic [95:0] rd_data_b, lyr_data_b;

    layer_stream_ctrl #(.WIDTH(8), .DRAIN_MAX(20)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .src_ready(src_ready_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .lyr_data(lyr_data_a), .lyr_valid(lyr_valid_a), .lyr_valid_out(lvo_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .busy(busy_a), .done(done_a),
        .err_timeout(err_to_a), .err_overflow(err_ov_a)
    );

    layer_stream_ctrl #(.WIDTH(112)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .src_ready(src_ready_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .lyr_data(lyr_data_b), .lyr_valid(lyr_valid_b), .lyr_valid_out(lvo_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .busy(busy_b), .done(done_b),
        .err_timeout(err_to_b), .err_overflow(err_ov_b)
    );

    function automatic logic [95:0] src_word(input int a);
        logic [31:0] v;
        v = a;
        return {v ^ 32'h5a5a_0000, v * 32'd7 + 32'd3, v + 32'h0000_1000};
    endfunction

    // Synchronous source RAMs: data one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= src_word(int'(rd_addr_a));
        if (rd_en_b) rd_data_b <= src_word(int'(rd_addr_b));
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_w(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard A ----------------
    ev_t exp_rd_a[$];
    ev_t exp_lv_a[$];
    int  exp_wr_a[$];
    int  exp_done_a[$];
    ev_t e_a;
    ev_t n_a;
    int  d_a;

    always @(negedge clk) begin
        if (rd_en_a) begin
            if (exp_rd_a.size() == 0) check("a_rd_unexpected", rd_en_a, 0);
            else begin
                e_a = exp_rd_a.pop_front();
                check("a_rd_addr", rd_addr_a, e_a.addr);
                check("a_rd_cycle", cyc, e_a.c);
                n_a.addr = e_a.addr;
                n_a.c    = cyc + 1;
                exp_lv_a.push_back(n_a);
            end
        end
        if (lyr_valid_a) begin
            if (exp_lv_a.size() == 0) check("a_lv_unexpected", lyr_valid_a, 0);
            else begin
                e_a = exp_lv_a.pop_front();
                check("a_lv_cycle", cyc, e_a.c);
                check_w("a_lv_data", lyr_data_a, src_word(e_a.addr));
            end
        end
        if (wr_en_a) begin
            check("a_wr_with_lvo", lvo_a, 1);
            if (exp_wr_a.size() == 0) check("a_wr_unexpected", wr_en_a, 0);
            else begin
                d_a = exp_wr_a.pop_front();
                check("a_wr_addr", wr_addr_a, d_a);
            end
        end
        if (done_a) begin
            if (exp_done_a.size() == 0) check("a_done_unexpected", done_a, 0);
            else begin
                d_a = exp_done_a.pop_front();
                check("a_done_cycle", cyc, d_a);
                check("a_busy_at_done", busy_a, 0);
            end
        end
    end

    // ---------------- scoreboard B ----------------
    int exp_lv_b[$];
    int exp_wr_b[$];
    int exp_done_b[$];
    int rd_idx_b = 0;
    int n_lv_b = 0;
    int n_wr_b = 0;
    int n_done_b = 0;
    bit fin_b = 1'b0;
    int d_b;

    always @(negedge clk) begin
        if (rd_en_b) begin
            check("b_rd_ready", src_ready_b, 1);
            check("b_rd_addr", rd_addr_b, rd_idx_b);
            rd_idx_b++;
        end
        if (lyr_valid_b) begin
            n_lv_b++;
            if (exp_lv_b.size() == 0) check("b_lv_unexpected", lyr_valid_b, 0);
            else begin
                d_b = exp_lv_b.pop_front();
                check_w("b_lv_data", lyr_data_b, src_word(d_b));
            end
        end
        if (wr_en_b) begin
            n_wr_b++;
            if (exp_wr_b.size() == 0) check("b_wr_unexpected", wr_en_b, 0);
            else begin
                d_b = exp_wr_b.pop_front();
                check("b_wr_addr", wr_addr_b, d_b);
            end
        end
        if (done_b) begin
            n_done_b++;
            fin_b = 1'b1;
            if (exp_done_b.size() == 0) check("b_done_unexpected", done_b, 0);
            else begin
                d_b = exp_done_b.pop_front();
                check("b_done_cycle", cyc, d_b);
            end
            check("b_err_timeout", err_to_b, 0);
            check("b_err_overflow", err_ov_b, 0);
        end
    end

    // ---------------- stimulus for A ----------------
    int s_a = 0;
    int lvo_lo = -100;
    int lvo_n = 0;
    int model_a = 0;
    int st0 = -1, st1 = -1, st2 = -1, st3 = -1;

    task automatic step_a();
        @(posedge clk);
        #1;
        start_a = (cyc == st0) || (cyc == st1) || (cyc == st2) || (cyc == st3);
        lvo_a   = (cyc >= lvo_lo) && (cyc < lvo_lo + lvo_n);
        if (lvo_a) begin
            if (model_a < DOUT_A) exp_wr_a.push_back(model_a);
            model_a++;
        end
    endtask

    task automatic at_a(input int c);
        while (cyc < c) step_a();
        @(negedge clk);
    endtask

    // Extra start pulses at offsets x1..x3 (0 = none); layer emits n pulses from offset off.
    task automatic frame_a(input int off, input int n, input int x1, input int x2, input int x3);
        ev_t e;
        s_a = cyc + 1;
        st0 = s_a;
        st1 = s_a + x1;
        st2 = s_a + x2;
        st3 = s_a + x3;
        lvo_lo  = s_a + off;
        lvo_n   = n;
        model_a = 0;
        for (int i = 0; i < DIM_A; i++) begin
            e.addr = i;
            e.c    = s_a + 1 + i;
            exp_rd_a.push_back(e);
        end
    endtask

    task automatic queues_empty_a(input string tag);
        check({tag, "_rd_left"}, exp_rd_a.size(), 0);
        check({tag, "_lv_left"}, exp_lv_a.size(), 0);
        check({tag, "_wr_left"}, exp_wr_a.size(), 0);
        check({tag, "_done_left"}, exp_done_a.size(), 0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] pipe;
        bit       pin;
        int       lv_seen;
        int       model_b;
        int       s_b;

        rst = 1'b1;
        start_a = 1'b0; src_ready_a = 1'b1; lvo_a = 1'b0;
        start_b = 1'b0; src_ready_b = 1'b0; lvo_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_lyr_valid", lyr_valid_a, 0);
        check("rst_wr_en", wr_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err_timeout", err_to_a, 0);
        check("rst_err_overflow", err_ov_a, 0);
        check("rst_rd_addr", rd_addr_a, 0);
        check("rst_wr_addr", wr_addr_a, 0);
        check("rst_busy_b", busy_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal frame: 64 reads, 16 outputs in DRAIN.
        frame_a(66, 16, 0, 0, 0);
        exp_done_a.push_back(s_a + 82);
        at_a(s_a + 1);
        check("t1_busy", busy_a, 1);
        check("t1_rd_en_first", rd_en_a, 1);
        check("t1_lv_not_yet", lyr_valid_a, 0);
        at_a(s_a + 2);
        check("t1_lv_first", lyr_valid_a, 1);
        at_a(s_a + 82);
        check("t1_done", done_a, 1);
        check("t1_busy_done", busy_a, 0);
        at_a(s_a + 83);
        check("t1_done_once", done_a, 0);
        check("t1_idle_busy", busy_a, 0);
        at_a(s_a + 88);
        check("t1_err_timeout", err_to_a, 0);
        check("t1_err_overflow", err_ov_a, 0);
        queues_empty_a("t1");

        // Drain timeout: layer stops after 10 outputs, last one at s+75.
        frame_a(66, 10, 0, 0, 0);
        exp_done_a.push_back(s_a + 96);
        at_a(s_a + 80);
        check("t3_wr_addr_hold", wr_addr_a, 10);
        check("t3_no_timeout_yet", err_to_a, 0);
        at_a(s_a + 95);
        check("t3_busy_before", busy_a, 1);
        check("t3_timeout_before", err_to_a, 0);
        at_a(s_a + 96);
        check("t3_err_timeout", err_to_a, 1);
        check("t3_wr_addr_done", wr_addr_a, 10);
        at_a(s_a + 100);
        check("t3_timeout_sticky", err_to_a, 1);
        queues_empty_a("t3");

        // Overflow: 17 outputs during FEED; done follows on the first DRAIN cycle.
        frame_a(10, 17, 0, 0, 0);
        exp_done_a.push_back(s_a + 66);
        at_a(s_a + 1);
        check("t4_timeout_cleared", err_to_a, 0);
        at_a(s_a + 26);
        check("t4_wr_en_17th", wr_en_a, 0);
        check("t4_ovf_not_yet", err_ov_a, 0);
        at_a(s_a + 27);
        check("t4_err_overflow", err_ov_a, 1);
        at_a(s_a + 66);
        check("t4_ovf_at_done", err_ov_a, 1);
        check("t4_no_timeout", err_to_a, 0);
        at_a(s_a + 70);
        queues_empty_a("t4");

        // Reset on the 30th read.
        frame_a(1000, 0, 0, 0, 0);
        at_a(s_a + 1);
        check("t5_ovf_cleared", err_ov_a, 0);
        while (cyc < s_a + 30) step_a();
        rst = 1'b1;
        exp_rd_a.delete();
        exp_lv_a.delete();
        at_a(s_a + 31);
        check("t5_rst_rd_en", rd_en_a, 0);
        check("t5_rst_lv", lyr_valid_a, 0);
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_rd_addr", rd_addr_a, 0);
        check("t5_rst_wr_addr", wr_addr_a, 0);
        step_a();
        rst = 1'b0;
        at_a(s_a + 33);
        check("t5_post_lv", lyr_valid_a, 0);
        check("t5_post_done", done_a, 0);

        // Recovery frame with start pulses in FEED, DRAIN and DONE.
        frame_a(66, 16, 20, 70, 82);
        exp_done_a.push_back(s_a + 82);
        at_a(s_a + 1);
        check("t6_rd_addr0", rd_addr_a, 0);
        at_a(s_a + 21);
        check("t6_rd_addr_after_start", rd_addr_a, 20);
        at_a(s_a + 71);
        check("t6_busy_drain", busy_a, 1);
        check("t6_wr_addr_drain", wr_addr_a, 5);
        at_a(s_a + 90);
        check("t6_busy_end", busy_a, 0);
        check("t6_rd_en_end", rd_en_a, 0);
        queues_empty_a("t6");

        // Full-size frame with a ~70% source throttle.
        s_b = cyc + 1;
        for (int i = 0; i < DIM_B; i++) exp_lv_b.push_back(i);
        pipe = '0;
        lv_seen = 0;
        model_b = 0;
        for (int k = 0; k < 30000 && !fin_b; k++) begin
            @(posedge clk);
            #1;
            start_b     = (cyc == s_b);
            src_ready_b = ($urandom_range(0, 9) < 7);
            pin = 1'b0;
            if (lyr_valid_b) begin
                lv_seen++;
                pin = ((lv_seen % 4) == 0);
            end
            pipe  = {pipe[1:0], pin};
            lvo_b = pipe[2];
            if (lvo_b) begin
                if (model_b < DOUT_B) exp_wr_b.push_back(model_b);
                model_b++;
                if (model_b == DOUT_B) exp_done_b.push_back(cyc + 1);
            end
        end
        check("b_done_seen", fin_b, 1);
        @(posedge clk);
        #1;
        start_b = 1'b0;
        src_ready_b = 1'b0;
        lvo_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("b_lv_count", n_lv_b, DIM_B);
        check("b_wr_count", n_wr_b, DOUT_B);
        check("b_done_count", n_done_b, 1);
        check("b_rd_count", rd_idx_b, DIM_B);
        check("b_busy_end", busy_b, 0);
        check("b_lv_left", exp_lv_b.size(), 0);
        check("b_wr_left", exp_wr_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
